// File: rtl/fpu_addsub_param.sv
// Parametrised multi-cycle floating-point adder/subtractor (RNE, FTZ, exception flags).
// Fixed five-cycle latency after launch; shares the start/busy/cmd_end handshake with the FPU top.
package pa_fpu;
  typedef enum logic [2:0] {
    op_add  = 3'd0,
    op_sub  = 3'd1,
    op_mul  = 3'd2,
    op_div  = 3'd3,
    op_sqrt = 3'd4
  } e_fpu_op;
endpackage

module fpu_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   srst_n,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a_operand,
  input  logic [EXP_W+MAN_W:0]   b_operand,
  input  pa_fpu::e_fpu_op        operation,
  output logic [EXP_W+MAN_W:0]   ieee_packet_out,
  output logic [3:0]             flags,
  output logic                   cmd_end,
  output logic                   busy
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int GW  = MAN_W + 4;
  localparam int LZW = $clog2(GW);
  localparam int XW  = ((EXP_W > LZW) ? EXP_W : LZW) + 2;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [XW-1:0]    EXP_LIM = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t state, state_nx;
  logic   armed, launch;

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    busy     = 1'b0;
    cmd_end  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && armed) begin
          launch   = 1'b1;
          state_nx = S_ALIGN;
        end
      end
      S_ALIGN: begin busy = 1'b1; state_nx = S_ADD;   end
      S_ADD:   begin busy = 1'b1; state_nx = S_NORM;  end
      S_NORM:  begin busy = 1'b1; state_nx = S_ROUND; end
      S_ROUND: begin busy = 1'b1; state_nx = S_DONE;  end
      S_DONE:  begin busy = 1'b1; cmd_end = 1'b1; state_nx = S_IDLE; end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state <= S_IDLE;
      armed <= 1'b1;
    end else begin
      state <= state_nx;
      if (launch)      armed <= 1'b0;
      else if (!start) armed <= 1'b1;
    end
  end

  logic [W-1:0]    a_q, b_q;
  pa_fpu::e_fpu_op op_q;

  always_ff @(posedge clk) begin
    if (launch) begin
      a_q  <= a_operand;
      b_q  <= b_operand;
      op_q <= operation;
    end
  end

  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_m, b_m, a_mf, b_mf;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b;
  logic [MAN_W:0]   a_sig, b_sig, big_sig, sml_sig;
  logic             big_s, sml_s;
  logic [EXP_W-1:0] big_e, sml_e, diff;
  logic [GW-1:0]    sml_ext, shifted, aligned;
  logic             sticky;

  always_comb begin
    a_s    = a_q[W-1];
    b_s    = b_q[W-1] ^ (op_q == pa_fpu::op_sub);
    a_e    = a_q[W-2:MAN_W];
    b_e    = b_q[W-2:MAN_W];
    a_m    = a_q[MAN_W-1:0];
    b_m    = b_q[MAN_W-1:0];
    a_zero = (a_e == '0);
    b_zero = (b_e == '0);
    a_inf  = (a_e == EXP_MAX) && (a_m == '0);
    b_inf  = (b_e == EXP_MAX) && (b_m == '0);
    a_nan  = (a_e == EXP_MAX) && (a_m != '0);
    b_nan  = (b_e == EXP_MAX) && (b_m != '0);
    // Subnormals carry exp==0, so dropping their fraction flushes them to signed zero.
    a_mf   = a_zero ? '0 : a_m;
    b_mf   = b_zero ? '0 : b_m;
    a_sig  = {~a_zero, a_mf};
    b_sig  = {~b_zero, b_mf};
    a_ge_b = ({a_e, a_mf} >= {b_e, b_mf});
    big_s   = a_ge_b ? a_s   : b_s;
    big_e   = a_ge_b ? a_e   : b_e;
    big_sig = a_ge_b ? a_sig : b_sig;
    sml_s   = a_ge_b ? b_s   : a_s;
    sml_e   = a_ge_b ? b_e   : a_e;
    sml_sig = a_ge_b ? b_sig : a_sig;
    diff    = big_e - sml_e;
    sml_ext = {sml_sig, 3'b000};
    shifted = sml_ext >> diff;
    sticky  = |(sml_ext & ~({GW{1'b1}} << diff));
    aligned = {shifted[GW-1:1], shifted[0] | sticky};
  end

  logic         sp_valid;
  logic [W-1:0] sp_res;
  logic [3:0]   sp_flags;

  always_comb begin
    sp_valid = 1'b0;
    sp_res   = '0;
    sp_flags = '0;
    if ((op_q != pa_fpu::op_add) && (op_q != pa_fpu::op_sub)) begin
      sp_valid = 1'b1;
      sp_res   = QNAN;
      sp_flags = 4'b1000;
    end else if (a_nan || b_nan) begin
      sp_valid = 1'b1;
      sp_res   = QNAN;
    end else if (a_inf && b_inf) begin
      sp_valid = 1'b1;
      if (a_s != b_s) begin
        sp_res   = QNAN;
        sp_flags = 4'b1000;
      end else begin
        sp_res = {a_s, EXP_MAX, {MAN_W{1'b0}}};
      end
    end else if (a_inf) begin
      sp_valid = 1'b1;
      sp_res   = {a_s, EXP_MAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      sp_valid = 1'b1;
      sp_res   = {b_s, EXP_MAX, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      sp_valid = 1'b1;
      sp_res   = {a_s & b_s, {(W-1){1'b0}}};
    end
  end

  logic             x_sign, x_sub;
  logic [EXP_W-1:0] x_exp;
  logic [GW-1:0]    x_big, x_sml;
  logic             sp_q;
  logic [W-1:0]     sp_res_q;
  logic [3:0]       sp_flags_q;
  logic [GW:0]      sum_q;
  logic [GW-1:0]    n_sig_d, n_sig_q;
  logic [XW-1:0]    n_exp_d, n_exp_q;
  logic             n_zero_q;
  logic [LZW-1:0]   lzc;

  always_comb begin
    lzc = '0;
    for (int unsigned i = 0; i < GW; i++)
      if (sum_q[i]) lzc = LZW'(GW - 1 - i);
  end

  always_comb begin
    if (sum_q[GW]) begin
      n_sig_d = {sum_q[GW:2], sum_q[1] | sum_q[0]};
      n_exp_d = XW'(x_exp) + XW'(1);
    end else begin
      n_sig_d = sum_q[GW-1:0] << lzc;
      n_exp_d = XW'(x_exp) - XW'(lzc);
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      S_ALIGN: begin
        x_sign     <= big_s;
        x_sub      <= big_s ^ sml_s;
        x_exp      <= big_e;
        x_big      <= {big_sig, 3'b000};
        x_sml      <= aligned;
        sp_q       <= sp_valid;
        sp_res_q   <= sp_res;
        sp_flags_q <= sp_flags;
      end
      S_ADD: sum_q <= x_sub ? ({1'b0, x_big} - {1'b0, x_sml})
                            : ({1'b0, x_big} + {1'b0, x_sml});
      S_NORM: begin
        n_sig_q  <= n_sig_d;
        n_exp_q  <= n_exp_d;
        n_zero_q <= (sum_q == '0);
      end
      default: ;
    endcase
  end

  logic             g_bit, r_bit, s_bit, inc;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] r_man;
  logic [XW-1:0]    r_exp;
  logic [W-1:0]     res_d;
  logic [3:0]       flags_d;

  always_comb begin
    g_bit = n_sig_q[2];
    r_bit = n_sig_q[1];
    s_bit = n_sig_q[0];
    inc   = g_bit & (r_bit | s_bit | n_sig_q[3]);
    rnd   = {1'b0, n_sig_q[GW-1:3]} + (MAN_W+2)'(inc);
    r_man = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    r_exp = n_exp_q + XW'(rnd[MAN_W+1]);
    res_d   = '0;
    flags_d = '0;
    if (sp_q) begin
      res_d   = sp_res_q;
      flags_d = sp_flags_q;
    end else if (n_zero_q) begin
      res_d = '0;
    end else if (n_exp_q[XW-1] || (n_exp_q == '0)) begin
      res_d   = {x_sign, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else if (r_exp >= EXP_LIM) begin
      res_d   = {x_sign, EXP_MAX, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else begin
      res_d   = {x_sign, r_exp[EXP_W-1:0], r_man};
      flags_d = {3'b000, g_bit | r_bit | s_bit};
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      ieee_packet_out <= '0;
      flags           <= '0;
    end else if (state == S_ROUND) begin
      ieee_packet_out <= res_d;
      flags           <= flags_d;
    end
  end

endmodule

// File: doc/fpu_addsub_param.md
Name: fpu_addsub_param

Overview:
- Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor; next generation of the single-precision FPU add/sub path.
- Format width is set by EXP_W/MAN_W (binary32 by default, binary16 etc. by override).
- Fixed latency; start/busy/cmd_end handshake is the same one the FPU top uses.
- Adds round-to-nearest-even, special-value handling and exception flags.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored mantissa field width (>=2); packet width W = 1+EXP_W+MAN_W

Ports:
clk  input  1  clock, all state on rising edge
srst_n  input  1  reset, synchronous, active-low
start  input  1  request; launches an operation when armed and in IDLE
a_operand  input  W  operand A, packed sign|exp|mantissa
b_operand  input  W  operand B, packed
operation  input  pa_fpu::e_fpu_op  op_add / op_sub; any other value is invalid
ieee_packet_out  output  W  result, held until next cmd_end
flags  output  4  {invalid, overflow, underflow, inexact}, updated with result
cmd_end  output  1  one-cycle pulse: result valid
busy  output  1  high while an operation is in progress

Behaviour:
- Reset (srst_n=0 at a rising edge):
  - state=IDLE; ieee_packet_out=0; flags=0; cmd_end=0; busy=0; armed=1.
  - Reset in any state aborts the operation; no cmd_end is produced.
- Arming:
  - Launch requires start=1 in IDLE with armed=1. Launch clears armed.
  - armed is set on any edge where start=0.
  - Holding start high across cmd_end therefore runs exactly one operation.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE, one cycle per state, no stalls.
  - Launch edge: capture operands and op into internal registers. Input changes after capture have no effect.
  - busy=1 from the cycle after the launch edge through the DONE cycle.
  - cmd_end=1 only in the DONE cycle, i.e. the 5th cycle after launch.
  - ieee_packet_out and flags are registered on entry to DONE and held until the next DONE.
- Unpack:
  - op_sub inverts B's sign.
  - exp==0 means zero; subnormals are flushed to signed zero (FTZ), no flag.
  - Hidden 1 is prepended to normals.
- ALIGN:
  - Swap so |A|>=|B| (compare exp then mantissa).
  - Shift B's significand right by the exponent difference in one cycle (barrel shift).
  - Working significand is MAN_W+1 bits plus guard, round and sticky bits; shifted-out bits OR into sticky.
  - A difference >= MAN_W+4 leaves only sticky.
- ADD: add if signs are equal, else subtract (never negative after the swap). One carry bit is kept.
- NORM:
  - Carry: shift right 1 (LSB ORs into sticky), exp+1.
  - Otherwise left-shift by the leading-zero count, computed in one cycle.
  - An exact zero gives +0 (sign 0).
- ROUND (RNE):
  - Increment if guard & (round|sticky|lsb).
  - inexact = guard|round|sticky.
  - Rounding carry-out renormalises and increments the exponent.
- Range:
  - Exponent >= all-ones after rounding: signed infinity; overflow=1, inexact=1.
  - Exponent <= 0 after normalise: signed zero; underflow=1, inexact=1.
- Specials, resolved at unpack with the result forced in DONE:
  - Any NaN input: canonical qNaN (0, exp all-ones, mantissa MSB=1).
  - inf - inf (effective subtract): qNaN, invalid=1.
  - inf ± finite: that inf.
  - Zero ± zero: -0 only if both effective signs are negative.
  - Invalid operation code: qNaN, invalid=1.
  - Latency is unchanged in all special cases.

Test Plan:
- Default params: a=0x3fffffff, b=0x402df854, op_sub -> 0xbf37e152, flags=0000, cmd_end exactly 5 cycles after launch, busy high 5 cycles.
- a=0x3f800000, b=0x3f8ccccd, op_add -> 0x40066666 (tie rounds to even), inexact=1; a=b=0x40490fda, op_sub -> 0x00000000, flags=0.
- a=b=0x7f7fffff, op_add -> 0x7f800000, flags=0101; a=b=0x7f800000, op_sub -> 0x7fc00000, flags=1000; a=0x7fc00001 with any b -> 0x7fc00000.
- Handshake:
  - Hold start=1 for 20 cycles -> exactly one cmd_end.
  - Drop start for 1 cycle, raise again -> second operation launches on the next IDLE edge.
  - Change a_operand during busy -> result unaffected.
- Assert srst_n=0 during NORM -> next cycle busy=0, no cmd_end, ieee_packet_out=0, flags=0. A fresh start then completes normally.
- EXP_W=5, MAN_W=10: 0x3c00+0x3c00 -> 0x4000; 0x7bff+0x7bff -> 0x7c00, overflow=1.
